// File: rtl/vowel_pkg.sv
// vowel_pkg: shared constants, FSM state type and popcount helper for vowel_insert.
package vowel_pkg;
    localparam logic [7:0] A = 8'd65;
    localparam logic [7:0] E = 8'd69;
    localparam logic [7:0] I = 8'd73;
    localparam logic [7:0] O = 8'd79;
    localparam logic [7:0] U = 8'd85;
    localparam logic [7:0] PAD = 8'd95;
    localparam int FRAME_LEN = 8;

    typedef enum logic [1:0] {IDLE, EMIT, DRAIN} state_t;

    function automatic logic [3:0] popcount8(input logic [7:0] m);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < FRAME_LEN; k++) n = n + 4'(m[k]);
        return n;
    endfunction
endpackage

// File: rtl/vowel_detect.sv
// vowel_detect: flags uppercase ASCII vowels.
module vowel_detect
    import vowel_pkg::*;
(
    input  logic [7:0] data,
    output logic       is_vowel
);
    assign is_vowel = data inside {A, E, I, O, U};
endmodule

// File: rtl/vowel_insert.sv
// vowel_insert: merges a consonant stream and a vowel stream into 8-char frames
// under a per-frame vowel mask, then drains the consonant stream's PAD fill.
module vowel_insert
    import vowel_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_valid,
    output logic       frame_ready,
    input  logic [7:0] frame_mask,
    input  logic [7:0] cons_data,
    input  logic       cons_valid,
    output logic       cons_ready,
    input  logic [7:0] vow_data,
    input  logic       vow_valid,
    output logic       vow_ready,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    input  logic       err_clr,
    output logic       vow_err,
    output logic       pad_err
);
    state_t     state;
    logic [2:0] pos;
    logic [3:0] pad_cnt;
    logic [7:0] mask;
    logic       slot_free, sel_vow, load_v, load_c, load, drain_acc, is_vowel;

    assign slot_free   = !out_valid || out_ready;
    assign sel_vow     = mask[pos];
    assign frame_ready = state == IDLE;
    assign vow_ready   = state == EMIT && sel_vow && slot_free;
    // DRAIN ignores the output slot: pad bytes never reach the output
    assign cons_ready  = state == DRAIN || (state == EMIT && !sel_vow && slot_free);
    assign load_v      = vow_valid && vow_ready;
    assign load_c      = cons_valid && cons_ready && state == EMIT;
    assign load        = load_v || load_c;
    assign drain_acc   = cons_valid && state == DRAIN;

    vowel_detect u_detect (.data(vow_data), .is_vowel(is_vowel));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pos       <= 3'd0;
            pad_cnt   <= 4'd0;
            mask      <= 8'd0;
            out_valid <= 1'b0;
            out_data  <= 8'd0;
            out_last  <= 1'b0;
            vow_err   <= 1'b0;
            pad_err   <= 1'b0;
        end else begin
            if (load) begin
                out_data  <= load_v ? vow_data : cons_data;
                out_valid <= 1'b1;
                out_last  <= pos == 3'(FRAME_LEN - 1);
                pos       <= pos + 3'd1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            vow_err <= (load_v && !is_vowel) || (vow_err && !err_clr);
            pad_err <= (drain_acc && cons_data != PAD) || (pad_err && !err_clr);
            case (state)
                IDLE: if (frame_valid) begin
                    mask    <= frame_mask;
                    pos     <= 3'd0;
                    pad_cnt <= popcount8(frame_mask);
                    state   <= EMIT;
                end
                EMIT: if (load && pos == 3'(FRAME_LEN - 1))
                    state <= pad_cnt == 4'd0 ? IDLE : DRAIN;
                DRAIN: if (cons_valid) begin
                    pad_cnt <= pad_cnt - 4'd1;
                    if (pad_cnt == 4'd1) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vowel_insert.sv
// tb_vowel_insert: scoreboard bench; stimulus pushes expected chars, a monitor pops on each output beat.
module tb_vowel_insert;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_valid = 1'b0, frame_ready;
    logic [7:0] frame_mask = 8'd0;
    logic [7:0] cons_data = 8'd0;
    logic       cons_valid = 1'b0, cons_ready;
    logic [7:0] vow_data = 8'd0;
    logic       vow_valid = 1'b0, vow_ready;
    logic [7:0] out_data;
    logic       out_valid, out_last;
    logic       out_ready = 1'b1;
    logic       err_clr = 1'b0, vow_err, pad_err;

    vowel_insert dut (
        .clk(clk), .rst(rst),
        .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_mask(frame_mask),
        .cons_data(cons_data), .cons_valid(cons_valid), .cons_ready(cons_ready),
        .vow_data(vow_data), .vow_valid(vow_valid), .vow_ready(vow_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
        .err_clr(err_clr), .vow_err(vow_err), .pad_err(pad_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [7:0] cons_q[$], vow_q[$];
    logic [8:0] exp_q[$];
    bit bp = 0, gaps = 0, exp_verr = 0, exp_perr = 0, held = 0;
    logic [7:0] held_data;
    logic [8:0] mon_e;
    int cyc = 0, bi = 0, first_cyc = 0, span = -1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // sources: present queue heads, pop when the handshake will complete at the next edge
    always @(negedge clk) begin
        cons_valid = cons_q.size() > 0 && !rst && (!gaps || $urandom_range(3) != 0);
        cons_data  = cons_valid ? cons_q[0] : 8'd0;
        vow_valid  = vow_q.size() > 0 && !rst && (!gaps || $urandom_range(3) != 0);
        vow_data   = vow_valid ? vow_q[0] : 8'd0;
        #1;
        if (cons_valid && cons_ready) void'(cons_q.pop_front());
        if (vow_valid && vow_ready) void'(vow_q.pop_front());
    end

    // monitor: drives out_ready, checks each beat against the scoreboard and stall stability
    always @(negedge clk) begin
        out_ready = !bp || $urandom_range(1) == 1;
        #1;
        if (rst) begin
            held = 0;
        end else begin
            if (held) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, held_data);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%0h required=none", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", out_data, mon_e[7:0]);
                    check("out_last", out_last, mon_e[8]);
                    if (bi == 0) first_cyc = cyc;
                    if (bi == 7) span = cyc - first_cyc;
                    bi = (bi + 1) % 8;
                end
            end
            held = out_valid && !out_ready;
            held_data = out_data;
        end
    end

    task automatic send_frame(input logic [7:0] m, input logic [7:0] c[8], input logic [7:0] v[8]);
        int ci = 0, vi = 0, n = 0;
        int nc = 8 - $countones(m);
        for (int k = 0; k < 8; k++) begin
            if (m[k]) begin
                exp_q.push_back({k == 7, v[vi]});
                if (!(v[vi] inside {8'd65, 8'd69, 8'd73, 8'd79, 8'd85})) exp_verr = 1;
                vi++;
            end else begin
                exp_q.push_back({k == 7, c[ci]});
                ci++;
            end
        end
        for (int k = 0; k < 8; k++) begin
            cons_q.push_back(c[k]);
            if (k >= nc && c[k] != 8'd95) exp_perr = 1;
        end
        for (int k = 0; k < 8 - nc; k++) vow_q.push_back(v[k]);
        @(negedge clk);
        frame_mask = m;
        frame_valid = 1;
        #2;
        while (!frame_ready && n < 500) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("frame_accept", frame_ready, 1);
        @(posedge clk);
        #1 frame_valid = 0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || cons_q.size() != 0 || vow_q.size() != 0 || !frame_ready || out_valid) && n < 3000) begin
            @(negedge clk);
            #2;
            n++;
        end
        check("idle_reached", n < 3000, 1);
    endtask

    task automatic check_reset_outputs();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_frame_ready", frame_ready, 1);
        check("rst_cons_ready", cons_ready, 0);
        check("rst_vow_ready", vow_ready, 0);
        check("rst_vow_err", vow_err, 0);
        check("rst_pad_err", pad_err, 0);
    endtask

    logic [7:0] c[8], v[8];
    logic [7:0] vtab[5];

    initial begin
        vtab = '{8'd65, 8'd69, 8'd73, 8'd79, 8'd85};
        repeat (2) @(negedge clk);
        #2 check_reset_outputs();
        @(negedge clk) rst = 0;

        // BEAUTIFY, full throughput, first beat two cycles after accept
        c = '{"B", "T", "F", "Y", 8'd95, 8'd95, 8'd95, 8'd95};
        v = '{"E", "A", "U", "I", 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(8'b0010_1110, c, v);
        @(negedge clk);
        #2 check("first_beat_not_early", out_valid, 0);
        @(negedge clk);
        #2 check("first_beat_on_time", out_valid, 1);
        check("first_beat_data", out_data, "B");
        wait_idle();
        check("beaut_span", span, 7);
        check("beaut_vow_err", vow_err, 0);
        check("beaut_pad_err", pad_err, 0);

        // no vowels: pass-through, DRAIN skipped
        c = '{"R", "H", "Y", "T", "H", "M", "S", "X"};
        send_frame(8'h00, c, v);
        begin
            int n = 0;
            while (!(out_valid && out_last) && n < 100) begin
                @(negedge clk);
                #2;
                n++;
            end
            check("m00_last_seen", out_valid && out_last, 1);
            check("m00_frame_ready", frame_ready, 1);
            check("m00_cons_ready", cons_ready, 0);
        end
        wait_idle();

        // all vowels, eight pad bytes drained
        c = '{8'd95, 8'd95, 8'd95, 8'd95, 8'd95, 8'd95, 8'd95, 8'd95};
        v = '{"A", "E", "I", "O", "U", "A", "E", "I"};
        send_frame(8'hFF, c, v);
        wait_idle();
        check("mff_pads_consumed", cons_q.size(), 0);
        check("mff_pad_err", pad_err, 0);
        check("mff_vow_err", vow_err, 0);

        // BEAUTIFY under random backpressure
        bp = 1;
        c = '{"B", "T", "F", "Y", 8'd95, 8'd95, 8'd95, 8'd95};
        v = '{"E", "A", "U", "I", 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(8'b0010_1110, c, v);
        wait_idle();
        bp = 0;

        // bad vowel and bad pad set sticky flags
        c = '{"B", "C", "D", "F", "G", "H", "J", 8'd65};
        v = '{8'd66, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(8'h01, c, v);
        wait_idle();
        check("bad_out_vow_err", vow_err, exp_verr);
        check("bad_out_pad_err", pad_err, exp_perr);
        repeat (5) @(negedge clk);
        #2 check("sticky_vow_err", vow_err, 1);
        check("sticky_pad_err", pad_err, 1);
        @(negedge clk) err_clr = 1;
        @(negedge clk) err_clr = 0;
        exp_verr = 0;
        exp_perr = 0;
        #2 check("clr_vow_err", vow_err, 0);
        check("clr_pad_err", pad_err, 0);

        // bad vowel at position 7 coincident with err_clr: set wins
        c = '{"B", "C", "D", "F", "G", "H", "J", 8'd95};
        v = '{8'd66, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(8'h80, c, v);
        repeat (8) @(negedge clk);
        err_clr = 1;
        @(negedge clk) err_clr = 0;
        #2 check("set_wins_vow_err", vow_err, exp_verr);
        wait_idle();

        // reset mid-frame at pos=3, then a clean frame
        c = '{"B", "T", "F", "Y", 8'd95, 8'd95, 8'd95, 8'd95};
        v = '{"E", "A", "U", "I", 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(8'b0010_1110, c, v);
        repeat (4) @(negedge clk);
        rst = 1;
        exp_q.delete();
        cons_q.delete();
        vow_q.delete();
        bi = 0;
        exp_verr = 0;
        exp_perr = 0;
        #2 check_reset_outputs();
        @(negedge clk) rst = 0;
        send_frame(8'b0010_1110, c, v);
        wait_idle();
        check("post_rst_vow_err", vow_err, exp_verr);

        // random frames with gaps and backpressure
        bp = 1;
        gaps = 1;
        for (int f = 0; f < 20; f++) begin
            logic [7:0] m;
            int nc;
            m = 8'($urandom);
            nc = 8 - $countones(m);
            for (int k = 0; k < 8; k++) begin
                c[k] = k < nc ? 8'($urandom_range(66, 90)) : 8'd95;
                v[k] = vtab[$urandom_range(4)];
            end
            send_frame(m, c, v);
        end
        wait_idle();
        check("rand_vow_err", vow_err, exp_verr);
        check("rand_pad_err", pad_err, exp_perr);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end
endmodule
